// File: rtl/cozy_alu_if.sv
// Operand/result bundle between the cozy CPU datapath and cozy_alu.
// The master (datapath) drives operands and op; the slave (ALU) returns result and flags.
interface cozy_alu_if;
  logic [15:0] rD;
  logic [15:0] rS;
  logic [3:0]  op;
  logic        carry_in;
  logic [15:0] out;
  logic        carry_out;
  logic        zero;
  logic        carry_flag;
  logic        zero_flag;

  modport master (
    output rD, rS, op, carry_in,
    input  out, carry_out, zero, carry_flag, zero_flag
  );

  modport slave (
    input  rD, rS, op, carry_in,
    output out, carry_out, zero, carry_flag, zero_flag
  );
endinterface : cozy_alu_if

// File: rtl/cozy_alu.sv
// 16-bit combinational ALU with carry/zero flags for the cozy CPU.
// Define COZY_ALU_FLAGS_REG_EN to register the flags; otherwise they mirror carry_out/zero.
module cozy_alu (
  input  logic        clk,
  input  logic        rst_n,
  cozy_alu_if.slave   bus
);

  typedef enum logic [3:0] {
    OP_MOV   = 4'h0,
    OP_AND   = 4'h1,
    OP_OR    = 4'h2,
    OP_XOR   = 4'h3,
    OP_SHR   = 4'h4,
    OP_SRC   = 4'h5,
    OP_SWP   = 4'h6,
    OP_NOT   = 4'h7,
    OP_ADD   = 4'h8,
    OP_ADC   = 4'h9,
    OP_INC   = 4'hA,
    OP_DEC   = 4'hB,
    OP_SUB   = 4'hC,
    OP_SBC   = 4'hD,
    OP_NEG   = 4'hE,
    OP_PASSD = 4'hF
  } alu_op_e;

  alu_op_e     w_op;
  logic [16:0] w_d17;
  logic [16:0] w_s17;
  logic [16:0] w_ci17;
  logic [16:0] w_res;
  logic        w_zero;

  assign w_op   = alu_op_e'(bus.op);
  assign w_d17  = {1'b0, bus.rD};
  assign w_s17  = {1'b0, bus.rS};
  assign w_ci17 = {16'h0000, bus.carry_in};

  // Bit 16 of w_res is carry for adds and borrow for subtracts: a 17-bit
  // unsigned difference wraps to 1xxxx exactly when the subtrahend is larger.
  always_comb begin
    // NOTE: default assigned first so every path writes w_res and no latch is inferred.
    w_res = 17'h0_0000;
    unique case (w_op)
      OP_MOV:   w_res = {1'b0, bus.rS};
      OP_AND:   w_res = {1'b0, bus.rD & bus.rS};
      OP_OR:    w_res = {1'b0, bus.rD | bus.rS};
      OP_XOR:   w_res = {1'b0, bus.rD ^ bus.rS};
      OP_SHR:   w_res = {bus.rS[0], 1'b0, bus.rS[15:1]};
      OP_SRC:   w_res = {bus.rS[0], bus.carry_in, bus.rS[15:1]};
      OP_SWP:   w_res = {1'b0, bus.rS[7:0], bus.rS[15:8]};
      OP_NOT:   w_res = {1'b0, ~bus.rS};
      OP_ADD:   w_res = w_d17 + w_s17;
      OP_ADC:   w_res = w_d17 + w_s17 + w_ci17;
      OP_INC:   w_res = w_s17 + 17'h0_0001;
      OP_DEC:   w_res = w_s17 - 17'h0_0001;
      OP_SUB:   w_res = w_d17 - w_s17;
      OP_SBC:   w_res = w_d17 - w_s17 - w_ci17;
      OP_NEG:   w_res = 17'h0_0000 - w_s17;
      OP_PASSD: w_res = {1'b0, bus.rD};
      default:  w_res = 17'h0_0000;
    endcase
  end

  assign w_zero        = (w_res[15:0] == 16'h0000);
  assign bus.out       = w_res[15:0];
  assign bus.carry_out = w_res[16];
  assign bus.zero      = w_zero;

`ifdef COZY_ALU_FLAGS_REG_EN
  logic r_carry_flag;
  logic r_zero_flag;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_carry_flag <= 1'b0;
      r_zero_flag  <= 1'b0;
    end else begin
      // NOTE: non-blocking so both flags sample the same pre-edge values.
      r_carry_flag <= w_res[16];
      r_zero_flag  <= w_zero;
    end
  end

  assign bus.carry_flag = r_carry_flag;
  assign bus.zero_flag  = r_zero_flag;
`else
  // Flags are pass-through in this build; clk/rst_n are deliberately unused.
  logic w_unused_clk_rst;
  assign w_unused_clk_rst = clk & rst_n;

  assign bus.carry_flag = w_res[16];
  assign bus.zero_flag  = w_zero;
`endif

endmodule : cozy_alu

// File: tb/tb_cozy_alu.sv
// Directed self-checking bench for cozy_alu; hand-computed vectors over all ops.
// Flag checks adapt to whether COZY_ALU_FLAGS_REG_EN is defined.
module tb_cozy_alu;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fails;

  cozy_alu_if bus ();

  cozy_alu dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [3:0]  op;
    logic [15:0] d;
    logic [15:0] s;
    logic        ci;
    logic [15:0] exp_out;
    logic        exp_co;
  } vec_t;

  vec_t vecs [25];

  task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fails++;
      $display("FAIL %s: got %h expected %h", tag, actual, expected);
    end
  endtask

  task automatic drive(input logic [3:0] op, input logic [15:0] d, input logic [15:0] s, input logic ci);
    bus.op       = op;
    bus.rD       = d;
    bus.rS       = s;
    bus.carry_in = ci;
  endtask

  initial begin
    n_checks = 0;
    n_fails  = 0;
    rst_n    = 1'b0;
    drive(4'h0, 16'h0000, 16'h0000, 1'b0);

    vecs[0]  = '{"mov",       4'h0, 16'h1234, 16'h5678, 1'b1, 16'h5678, 1'b0};
    vecs[1]  = '{"and",       4'h1, 16'h1234, 16'h2345, 1'b0, 16'h0204, 1'b0};
    vecs[2]  = '{"or",        4'h2, 16'h1234, 16'h2345, 1'b0, 16'h3375, 1'b0};
    vecs[3]  = '{"xor",       4'h3, 16'h1234, 16'h2345, 1'b0, 16'h3171, 1'b0};
    vecs[4]  = '{"swp",       4'h6, 16'h1234, 16'h5678, 1'b0, 16'h7856, 1'b0};
    vecs[5]  = '{"not",       4'h7, 16'h1234, 16'hAAAA, 1'b0, 16'h5555, 1'b0};
    vecs[6]  = '{"shr",       4'h4, 16'h1234, 16'h2345, 1'b0, 16'h11A2, 1'b1};
    vecs[7]  = '{"src_ci1",   4'h5, 16'h0000, 16'h1234, 1'b1, 16'h891A, 1'b0};
    vecs[8]  = '{"shr_ci1",   4'h4, 16'h0000, 16'h1234, 1'b1, 16'h091A, 1'b0};
    vecs[9]  = '{"add_max",   4'h8, 16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFE, 1'b1};
    vecs[10] = '{"adc_max",   4'h9, 16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1};
    vecs[11] = '{"adc_wrap",  4'h9, 16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1};
    vecs[12] = '{"inc_wrap",  4'hA, 16'h1234, 16'hFFFF, 1'b0, 16'h0000, 1'b1};
    vecs[13] = '{"dec_zero",  4'hB, 16'h1234, 16'h0000, 1'b0, 16'hFFFF, 1'b1};
    vecs[14] = '{"dec_max",   4'hB, 16'h1234, 16'hFFFF, 1'b0, 16'hFFFE, 1'b0};
    vecs[15] = '{"sub_brw",   4'hC, 16'h1234, 16'h5678, 1'b1, 16'hBBBC, 1'b1};
    vecs[16] = '{"sbc_ci1",   4'hD, 16'h1000, 16'h0001, 1'b1, 16'h0FFE, 1'b0};
    vecs[17] = '{"sbc_max",   4'hD, 16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1};
    vecs[18] = '{"neg",       4'hE, 16'h1234, 16'hAAAA, 1'b0, 16'h5556, 1'b1};
    vecs[19] = '{"neg_zero",  4'hE, 16'h1234, 16'h0000, 1'b0, 16'h0000, 1'b0};
    vecs[20] = '{"passd",     4'hF, 16'hBEEF, 16'h1111, 1'b1, 16'hBEEF, 1'b0};
    vecs[21] = '{"add_ci_ign",4'h8, 16'h0001, 16'h0002, 1'b1, 16'h0003, 1'b0};
    vecs[22] = '{"sub_eq",    4'hC, 16'h4321, 16'h4321, 1'b1, 16'h0000, 1'b0};
    vecs[23] = '{"adc_ci0",   4'h9, 16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1};
    vecs[24] = '{"inc_small", 4'hA, 16'hFFFF, 16'h00FF, 1'b1, 16'h0100, 1'b0};

    // Combinational outputs must track inputs even while held in reset.
    @(negedge clk);
    drive(4'h8, 16'h0001, 16'h0002, 1'b0);
    #1;
    check("in_reset_out", 32'(bus.out), 32'h0003);
`ifdef COZY_ALU_FLAGS_REG_EN
    check("reset_cflag", 32'(bus.carry_flag), 32'h0);
    check("reset_zflag", 32'(bus.zero_flag), 32'h0);
`endif
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      drive(vecs[i].op, vecs[i].d, vecs[i].s, vecs[i].ci);
      #1;
      check({vecs[i].tag, "_out"},  32'(bus.out),       32'(vecs[i].exp_out));
      check({vecs[i].tag, "_co"},   32'(bus.carry_out), 32'(vecs[i].exp_co));
      check({vecs[i].tag, "_zero"}, 32'(bus.zero),      32'(vecs[i].exp_out == 16'h0000));
`ifndef COZY_ALU_FLAGS_REG_EN
      check({vecs[i].tag, "_cflag"}, 32'(bus.carry_flag), 32'(vecs[i].exp_co));
      check({vecs[i].tag, "_zflag"}, 32'(bus.zero_flag),  32'(vecs[i].exp_out == 16'h0000));
`endif
    end

`ifdef COZY_ALU_FLAGS_REG_EN
    // Load carry=1, zero=0, then confirm the flags hold until the next edge.
    @(negedge clk);
    drive(4'h8, 16'hFFFF, 16'hFFFF, 1'b0);
    @(posedge clk);
    #1;
    check("load_cflag", 32'(bus.carry_flag), 32'h1);
    check("load_zflag", 32'(bus.zero_flag), 32'h0);
    drive(4'hC, 16'h0005, 16'h0005, 1'b0);
    #1;
    check("hold_cflag", 32'(bus.carry_flag), 32'h1);
    check("hold_zflag", 32'(bus.zero_flag), 32'h0);

    // Async reset mid-cycle clears flags without a clock edge.
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_cflag", 32'(bus.carry_flag), 32'h0);
    check("async_rst_zflag", 32'(bus.zero_flag), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    drive(4'hC, 16'hFFFF, 16'hFFFF, 1'b0);
    @(posedge clk);
    #1;
    check("sub_eq_zflag", 32'(bus.zero_flag), 32'h1);
    check("sub_eq_cflag", 32'(bus.carry_flag), 32'h0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fails);
    $finish;
  end

endmodule : tb_cozy_alu
